// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD scan-out path.
// Contents: FSM state enum, panel geometry, init ROM, window sequence,
// RGB332 colour conversion helper.
package lcd_pkg;

   typedef enum logic [2:0] {PRST, WAKE, INIT, WIN, PIX, DONE} state_e;

   localparam int unsigned LCD_W    = 128;
   localparam int unsigned LCD_H    = 128;
   localparam int unsigned NPIX     = LCD_W * LCD_H;
   localparam int unsigned ADDR_W   = 14;
   localparam int unsigned INIT_LEN = 6;
   localparam int unsigned WIN_LEN  = 11;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_RASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   // One bus byte: cd=0 command, cd=1 data.
   typedef struct packed {
      logic       cd;
      logic [7:0] data;
   } lcd_byte_t;

   // Panel power-up sequence, sent once after reset.
   function automatic lcd_byte_t init_byte(input logic [3:0] idx);
      case (idx)
         4'd0:    init_byte = '{cd: 1'b0, data: 8'h01};  // software reset
         4'd1:    init_byte = '{cd: 1'b0, data: 8'h11};  // sleep out
         4'd2:    init_byte = '{cd: 1'b0, data: 8'h3A};  // pixel format
         4'd3:    init_byte = '{cd: 1'b1, data: 8'h02};  // 8-bit RGB332
         4'd4:    init_byte = '{cd: 1'b0, data: 8'h36};  // MADCTL
         4'd5:    init_byte = '{cd: 1'b1, data: 8'h00};
         default: init_byte = '{cd: 1'b0, data: 8'h00};
      endcase
   endfunction

   // Full-screen column/row window followed by memory write.
   function automatic lcd_byte_t win_byte(input logic [3:0] idx);
      case (idx)
         4'd0:    win_byte = '{cd: 1'b0, data: CMD_CASET};
         4'd4:    win_byte = '{cd: 1'b1, data: 8'(LCD_W - 1)};
         4'd5:    win_byte = '{cd: 1'b0, data: CMD_RASET};
         4'd9:    win_byte = '{cd: 1'b1, data: 8'(LCD_H - 1)};
         4'd10:   win_byte = '{cd: 1'b0, data: CMD_RAMWR};
         default: win_byte = '{cd: 1'b1, data: 8'h00};
      endcase
   endfunction

   // {r,g,b} single bits replicated into RGB332.
   function automatic logic [7:0] rgb332(input logic [2:0] rgb);
      rgb332 = {{3{rgb[2]}}, {3{rgb[1]}}, {2{rgb[0]}}};
   endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// Single-byte writer for the 8080-style LCD bus.
// Ports: clk_i, rst_i (sync, active high); start_i/cd_i/data_i load a byte;
// lcd_cd_o/lcd_d_o held for the whole byte, lcd_wr_o low for the first
// WR_HALF cycles; busy_o while a byte is on the bus; last_o in its final cycle.
// start_i on the last_o cycle chains the next byte with no gap.
module lcd_byte_tx
   import lcd_pkg::*;
#(
   parameter int unsigned WR_HALF = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic       cd_i,
   input  logic [7:0] data_i,
   output logic       lcd_cd_o,
   output logic [7:0] lcd_d_o,
   output logic       lcd_wr_o,
   output logic       busy_o,
   output logic       last_o
);

   localparam int unsigned BYTE_CYC = 2 * WR_HALF;
   localparam int unsigned CNT_W    = (BYTE_CYC > 2) ? $clog2(BYTE_CYC) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             wr_q, wr_d;
   logic             last_q, last_d;
   logic             cd_q, cd_d;
   logic [7:0]       d_q, d_d;

   // Byte sequencing; strobe and last flag are decoded from the next count
   // so they come straight out of flops.
   always_comb begin
      cnt_d  = cnt_q;
      busy_d = busy_q;
      cd_d   = cd_q;
      d_d    = d_q;
      if (start_i) begin
         cnt_d  = '0;
         busy_d = 1'b1;
         cd_d   = cd_i;
         d_d    = data_i;
      end else if (busy_q) begin
         if (cnt_q == CNT_W'(BYTE_CYC - 1)) begin
            cnt_d  = '0;
            busy_d = 1'b0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      wr_d   = !(busy_d && (cnt_d < CNT_W'(WR_HALF)));
      last_d = busy_d && (cnt_d == CNT_W'(BYTE_CYC - 1));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
         wr_q   <= 1'b1;
         last_q <= 1'b0;
         cd_q   <= 1'b0;
         d_q    <= '0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         wr_q   <= wr_d;
         last_q <= last_d;
         cd_q   <= cd_d;
         d_q    <= d_d;
      end
   end

   assign lcd_cd_o = cd_q;
   assign lcd_d_o  = d_q;
   assign lcd_wr_o = wr_q;
   assign busy_o   = busy_q;
   assign last_o   = last_q;

endmodule

// File: rtl/lcd_scanout.sv
// Display-side VRAM reader: resets and initialises the panel, then streams
// full 128x128 RGB332 frames over the 8-bit parallel LCD bus forever.
// Ports: CLK, RST (sync, active high); VRAM_RADDR {y,x} / VRAM_RDATA
// (one-cycle read latency); LCD_CS0, LCD_CD, LCD_WR, LCD_RSTB, LCD_D panel
// bus; FRAME_DONE one-cycle pulse after each frame's last pixel byte.
// WR_HALF must be at least 2 so a pixel fetch lands inside one byte period.
module lcd_scanout
   import lcd_pkg::*;
#(
   parameter int unsigned WR_HALF     = 4,
   parameter int unsigned RST_CYCLES  = 1024,
   parameter int unsigned WAKE_CYCLES = 4096
) (
   input  logic              CLK,
   input  logic              RST,
   output logic [ADDR_W-1:0] VRAM_RADDR,
   input  logic [3:0]        VRAM_RDATA,
   output logic              LCD_CS0,
   output logic              LCD_CD,
   output logic              LCD_WR,
   output logic              LCD_RSTB,
   output logic [7:0]        LCD_D,
   output logic              FRAME_DONE
);

   localparam int unsigned TMR_MAX = (RST_CYCLES > WAKE_CYCLES) ? RST_CYCLES : WAKE_CYCLES;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

   state_e            state_q, state_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [3:0]        idx_q, idx_d;
   logic [ADDR_W-1:0] pcnt_q, pcnt_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic [7:0]        pix_q, pix_d;
   logic              cs_q, cs_d;
   logic              rstb_q, rstb_d;
   logic              fd_q, fd_d;

   logic              start_c;
   lcd_byte_t         tx_byte_c;
   logic              tx_last;
   logic              unused_tx_busy;
   logic              unused_rdata_msb;

   assign unused_rdata_msb = VRAM_RDATA[3];

   // Sequencer: panel reset/wake timers, then init, window and pixel bytes.
   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      idx_d     = idx_q;
      pcnt_d    = pcnt_q;
      raddr_d   = raddr_q;
      pix_d     = pix_q;
      cs_d      = cs_q;
      rstb_d    = rstb_q;
      fd_d      = 1'b0;
      start_c   = 1'b0;
      tx_byte_c = '{cd: 1'b0, data: 8'h00};

      // Keep refreshing the pixel register while the next address is held;
      // the last capture before the byte boundary is the valid one.
      if ((state_q == WIN || state_q == PIX) && !tx_last) begin
         pix_d = rgb332(VRAM_RDATA[2:0]);
      end

      case (state_q)
         PRST: begin
            rstb_d = 1'b0;
            cs_d   = 1'b1;
            if (tmr_q == TMR_W'(RST_CYCLES - 1)) begin
               state_d = WAKE;
               tmr_d   = '0;
               rstb_d  = 1'b1;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         WAKE: begin
            if (tmr_q == TMR_W'(WAKE_CYCLES - 1)) begin
               state_d   = INIT;
               tmr_d     = '0;
               cs_d      = 1'b0;
               idx_d     = '0;
               start_c   = 1'b1;
               tx_byte_c = init_byte(4'd0);
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         INIT: begin
            if (tx_last) begin
               start_c = 1'b1;
               if (idx_q == 4'(INIT_LEN - 1)) begin
                  state_d   = WIN;
                  idx_d     = '0;
                  tx_byte_c = win_byte(4'd0);
               end else begin
                  idx_d     = idx_q + 4'd1;
                  tx_byte_c = init_byte(idx_q + 4'd1);
               end
            end
         end
         WIN: begin
            // Address 0 is presented for the whole window so pixel 0 is ready.
            raddr_d = '0;
            pcnt_d  = '0;
            if (tx_last) begin
               start_c = 1'b1;
               if (idx_q == 4'(WIN_LEN - 1)) begin
                  state_d   = PIX;
                  idx_d     = '0;
                  raddr_d   = ADDR_W'(1);
                  tx_byte_c = '{cd: 1'b1, data: pix_q};
               end else begin
                  idx_d     = idx_q + 4'd1;
                  tx_byte_c = win_byte(idx_q + 4'd1);
               end
            end
         end
         PIX: begin
            if (tx_last) begin
               if (pcnt_q == ADDR_W'(NPIX - 1)) begin
                  state_d = DONE;
                  fd_d    = 1'b1;
                  pcnt_d  = '0;
                  raddr_d = '0;
               end else begin
                  start_c   = 1'b1;
                  tx_byte_c = '{cd: 1'b1, data: pix_q};
                  pcnt_d    = pcnt_q + ADDR_W'(1);
                  // Fetch runs one pixel ahead; wraps to {0,0} naturally.
                  raddr_d   = raddr_q + ADDR_W'(1);
               end
            end
         end
         DONE: begin
            state_d   = WIN;
            idx_d     = '0;
            raddr_d   = '0;
            start_c   = 1'b1;
            tx_byte_c = win_byte(4'd0);
         end
         default: begin
            state_d = PRST;
            tmr_d   = '0;
            cs_d    = 1'b1;
            rstb_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= PRST;
         tmr_q   <= '0;
         idx_q   <= '0;
         pcnt_q  <= '0;
         raddr_q <= '0;
         pix_q   <= '0;
         cs_q    <= 1'b1;
         rstb_q  <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         idx_q   <= idx_d;
         pcnt_q  <= pcnt_d;
         raddr_q <= raddr_d;
         pix_q   <= pix_d;
         cs_q    <= cs_d;
         rstb_q  <= rstb_d;
         fd_q    <= fd_d;
      end
   end

   lcd_byte_tx #(.WR_HALF(WR_HALF)) u_tx (
      .clk_i    (CLK),
      .rst_i    (RST),
      .start_i  (start_c),
      .cd_i     (tx_byte_c.cd),
      .data_i   (tx_byte_c.data),
      .lcd_cd_o (LCD_CD),
      .lcd_d_o  (LCD_D),
      .lcd_wr_o (LCD_WR),
      .busy_o   (unused_tx_busy),
      .last_o   (tx_last)
   );

   assign VRAM_RADDR = raddr_q;
   assign LCD_CS0    = cs_q;
   assign LCD_RSTB   = rstb_q;
   assign FRAME_DONE = fd_q;

endmodule

// File: tb/tb_lcd_scanout.sv
// Bench for lcd_scanout: expected bus bytes are queued by the stimulus
// process and checked by a monitor on every LCD_WR rising edge.
module tb_lcd_scanout;
   import lcd_pkg::*;

   // Short timers and WR_HALF=2 keep a full frame plus a partial second
   // frame and a re-initialisation within a modest cycle count.
   localparam int unsigned WRH       = 2;
   localparam int unsigned RSTC      = 64;
   localparam int unsigned WAKEC     = 256;
   localparam int unsigned BYTE      = 2 * WRH;
   localparam int unsigned FRAME_CYC = (WIN_LEN + NPIX) * BYTE + 1;

   localparam logic [8:0] INIT_EXP [6] = '{9'h001, 9'h011, 9'h03A, 9'h102, 9'h036, 9'h100};
   localparam logic [8:0] WIN_EXP [11] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h17F,
                                           9'h02B, 9'h100, 9'h100, 9'h100, 9'h17F, 9'h02C};
   // RGB332 of {r,g,b} = 0..7, worked out by hand.
   localparam logic [7:0] RGB_TAB [8] = '{8'h00, 8'h03, 8'h1C, 8'h1F, 8'hE0, 8'hE3, 8'hFC, 8'hFF};

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic [ADDR_W-1:0] VRAM_RADDR;
   logic [3:0]        VRAM_RDATA;
   logic              LCD_CS0, LCD_CD, LCD_WR, LCD_RSTB, FRAME_DONE;
   logic [7:0]        LCD_D;

   always #5 CLK = ~CLK;

   lcd_scanout #(.WR_HALF(WRH), .RST_CYCLES(RSTC), .WAKE_CYCLES(WAKEC)) dut (
      .CLK(CLK), .RST(RST), .VRAM_RADDR(VRAM_RADDR), .VRAM_RDATA(VRAM_RDATA),
      .LCD_CS0(LCD_CS0), .LCD_CD(LCD_CD), .LCD_WR(LCD_WR), .LCD_RSTB(LCD_RSTB),
      .LCD_D(LCD_D), .FRAME_DONE(FRAME_DONE)
   );

   // VRAM with one-cycle read latency.
   logic [3:0] vram [NPIX];
   always @(posedge CLK) VRAM_RDATA <= vram[VRAM_RADDR];

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [8:0] exp_q [$];
   int         win_fall [$];
   int         fd_cnt = 0;
   int         nbytes = 0;

   function automatic void chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // ---------------- monitor ----------------
   logic prev_wr = 1'b1;
   logic prev_cd = 1'b0;
   logic [7:0] prev_d = 8'h00;
   int   since_fall = -1;
   int   low_len = 0;
   int   last_fall = 0;
   bit   fall_valid = 1'b0;
   bit   fd_since = 1'b0;

   always @(negedge CLK) begin
      if (RST) begin
         since_fall = -1;
         fall_valid = 1'b0;
      end else begin
         if (FRAME_DONE) begin
            fd_cnt++;
            fd_since = 1'b1;
         end
         if (prev_wr && !LCD_WR && !LCD_CS0) begin
            if (fall_valid && !fd_since)
               chk("byte_period", cyc - last_fall, BYTE);
            last_fall  = cyc;
            fall_valid = 1'b1;
            fd_since   = 1'b0;
            since_fall = 0;
            low_len    = 1;
            if ({LCD_CD, LCD_D} == 9'h02A) win_fall.push_back(cyc);
         end else begin
            if (!LCD_WR) low_len++;
            if (since_fall >= 0 && since_fall < 1000) since_fall++;
            if (since_fall >= 1 && since_fall < int'(BYTE))
               chk("bus_hold", {LCD_CD, LCD_D}, {prev_cd, prev_d});
         end
         if (!prev_wr && LCD_WR && !LCD_CS0) begin
            chk("wr_low_len", low_len, WRH);
            if (exp_q.size() == 0) begin
               chk("unexpected_byte", {LCD_CD, LCD_D}, 9'h1FF);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               if ({LCD_CD, LCD_D} != e)
                  $display("FAIL lcd_byte #%0d: got cd=%0d d=0x%02h expected cd=%0d d=0x%02h",
                           nbytes, LCD_CD, LCD_D, e[8], e[7:0]);
               n_cmp++;
               if ({LCD_CD, LCD_D} != e) n_err++;
            end
            nbytes++;
         end
      end
      prev_wr = LCD_WR;
      prev_cd = LCD_CD;
      prev_d  = LCD_D;
   end

   // ---------------- stimulus ----------------
   task automatic push_init();
      for (int i = 0; i < 6; i++) exp_q.push_back(INIT_EXP[i]);
   endtask

   task automatic push_win();
      for (int i = 0; i < 11; i++) exp_q.push_back(WIN_EXP[i]);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cs0"}, LCD_CS0, 1);
      chk({tag, "_cd"}, LCD_CD, 0);
      chk({tag, "_wr"}, LCD_WR, 1);
      chk({tag, "_rstb"}, LCD_RSTB, 0);
      chk({tag, "_d"}, LCD_D, 0);
      chk({tag, "_raddr"}, VRAM_RADDR, 0);
      chk({tag, "_frame_done"}, FRAME_DONE, 0);
   endtask

   // Called right after RST is released: measures panel reset and wake time.
   task automatic reset_timing(input string tag);
      int n;
      n = 0;
      @(negedge CLK);
      while (LCD_RSTB == 1'b0 && n < int'(4 * RSTC)) begin n++; @(negedge CLK); end
      chk({tag, "_rstb_low_cycles"}, n, RSTC);
      chk({tag, "_cs0_in_wake"}, LCD_CS0, 1);
      n = 0;
      while (LCD_WR && n < int'(4 * WAKEC)) begin n++; @(negedge CLK); end
      chk({tag, "_wake_cycles"}, n, WAKEC);
      chk({tag, "_first_byte"}, {LCD_CS0, LCD_CD, LCD_D}, 10'h001);
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin n++; @(negedge CLK); end
      chk({tag, "_queue_left"}, exp_q.size(), 0);
   endtask

   initial begin
      int n;
      int done_cyc;
      // Frame 1: pixel {y,x} = (x+y)%8, with a random ignored MSB.
      for (int a = 0; a < int'(NPIX); a++) begin
         vram[a][2:0] = 3'((a % 128 + a / 128) % 8);
         vram[a][3]   = 1'($urandom_range(0, 1));
      end
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check_reset_outputs("reset");
      push_init();
      push_win();
      for (int k = 0; k < int'(NPIX); k++)
         exp_q.push_back({1'b1, RGB_TAB[(k % 128 + k / 128) % 8]});
      @(posedge CLK);
      #1 RST = 1'b0;
      reset_timing("boot");

      n = 0;
      while (!FRAME_DONE && n < int'(FRAME_CYC + 1000)) begin n++; @(negedge CLK); end
      chk("f1_frame_done_seen", FRAME_DONE, 1);
      done_cyc = cyc;
      chk("f1_all_bytes_seen", exp_q.size(), 0);
      chk("f1_win_fall_count", win_fall.size(), 1);
      if (win_fall.size() > 0)
         chk("f1_done_offset", done_cyc - win_fall[0], (WIN_LEN + NPIX) * BYTE);
      // Frame 2: fully random contents, loaded while the bus is idle in DONE.
      for (int a = 0; a < int'(NPIX); a++) vram[a] = 4'($urandom_range(0, 15));
      push_win();
      for (int k = 0; k < 5000; k++) exp_q.push_back({1'b1, RGB_TAB[vram[k][2:0]]});
      @(negedge CLK);
      chk("frame_done_width", FRAME_DONE, 0);

      n = 0;
      while (win_fall.size() < 2 && n < 1000) begin n++; @(negedge CLK); end
      chk("f2_win_fall_count", win_fall.size(), 2);
      if (win_fall.size() >= 2)
         chk("frame_period", win_fall[1] - win_fall[0], FRAME_CYC);
      chk("frame_done_pulses", fd_cnt, 1);

      // Reset in the middle of pixel 5000 while LCD_WR is low.
      wait_drain("f2", 30000);
      n = 0;
      while (LCD_WR && n < 100) begin n++; @(negedge CLK); end
      chk("pix5000_wr_low", {LCD_WR, LCD_CS0, LCD_CD}, 3'b001);
      #1 RST = 1'b1;
      @(negedge CLK);
      check_reset_outputs("midframe_reset");
      push_init();
      push_win();
      @(posedge CLK);
      #1 RST = 1'b0;
      reset_timing("reinit");
      wait_drain("reinit", 1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
